// File: rtl/mux2_arbiter.sv
// mux2_arbiter: round-robin arbiter that shares one 8-bit 2-to-1 mux channel
// between two burst requesters and registers the selected byte into a
// valid/ready output stage. A grant lasts for one burst and ends on `last`,
// on a forced MAX_BURST cut, or on a stall timeout.
module mux2_arbiter #(
  parameter int MAX_BURST   = 8,
  parameter int STALL_LIMIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [7:0] data0,
  input  logic       last0,
  output logic       ack0,
  input  logic       req1,
  input  logic [7:0] data1,
  input  logic       last1,
  output logic       ack1,
  output logic       sel,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  // Counter values at which a burst is cut or a stalled grant is revoked.
  localparam logic [7:0] BEAT_LAST  = 8'(MAX_BURST - 1);
  localparam logic [7:0] STALL_LAST = 8'(STALL_LIMIT - 1);

  state_t     state_r, state_s;
  logic       prio_r, prio_s;
  logic       sel_r, sel_s;
  logic [7:0] out_data_r, out_data_s;
  logic       out_valid_r, out_valid_s;
  logic       out_last_r, out_last_s;
  logic [7:0] beat_cnt_r, beat_cnt_s;
  logic [7:0] stall_cnt_r, stall_cnt_s;

  logic       granted_s;
  logic       gnt_req_s;
  logic [7:0] gnt_data_s;
  logic       gnt_last_s;
  logic       capture_s;

  // Shared channel: sel picks the requester; a capture needs an active grant,
  // a pending beat, and room in the output register.
  always_comb begin
    granted_s  = (state_r != IDLE);
    gnt_req_s  = sel_r ? req1  : req0;
    gnt_data_s = sel_r ? data1 : data0;
    gnt_last_s = sel_r ? last1 : last0;
    capture_s  = granted_s && gnt_req_s && (!out_valid_r || out_ready);
  end

  // Next-state logic: output stage handshake, arbitration, burst release and
  // stall timeout.
  always_comb begin
    state_s     = state_r;
    prio_s      = prio_r;
    sel_s       = sel_r;
    out_data_s  = out_data_r;
    out_valid_s = out_valid_r;
    out_last_s  = out_last_r;
    beat_cnt_s  = beat_cnt_r;
    stall_cnt_s = stall_cnt_r;

    if (capture_s) begin
      out_data_s  = gnt_data_s;
      out_valid_s = 1'b1;
      out_last_s  = gnt_last_s || (beat_cnt_r == BEAT_LAST);
    end else if (out_valid_r && out_ready) begin
      out_valid_s = 1'b0;
      out_last_s  = 1'b0;
    end else begin
      out_valid_s = out_valid_r;
      out_last_s  = out_last_r;
    end

    case (state_r)
      IDLE: begin
        if (req0 && (!req1 || !prio_r)) begin
          state_s = GNT0;
          sel_s   = 1'b0;
        end else if (req1) begin
          state_s = GNT1;
          sel_s   = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      GNT0, GNT1: begin
        if (capture_s && out_last_s) begin
          // Burst closed (natural or forced): hand priority to the peer.
          state_s     = IDLE;
          prio_s      = ~sel_r;
          beat_cnt_s  = 8'd0;
          stall_cnt_s = 8'd0;
        end else if (gnt_req_s) begin
          stall_cnt_s = 8'd0;
          if (capture_s) begin
            beat_cnt_s = beat_cnt_r + 8'd1;
          end else begin
            beat_cnt_s = beat_cnt_r;
          end
        end else if (stall_cnt_r == STALL_LAST) begin
          // Requester went quiet too long: revoke without emitting a beat.
          state_s     = IDLE;
          prio_s      = ~sel_r;
          beat_cnt_s  = 8'd0;
          stall_cnt_s = 8'd0;
        end else begin
          stall_cnt_s = stall_cnt_r + 8'd1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers; reset dominates every other event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      prio_r      <= 1'b0;
      sel_r       <= 1'b0;
      out_data_r  <= 8'd0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      beat_cnt_r  <= 8'd0;
      stall_cnt_r <= 8'd0;
    end else begin
      state_r     <= state_s;
      prio_r      <= prio_s;
      sel_r       <= sel_s;
      out_data_r  <= out_data_s;
      out_valid_r <= out_valid_s;
      out_last_r  <= out_last_s;
      beat_cnt_r  <= beat_cnt_s;
      stall_cnt_r <= stall_cnt_s;
    end
  end

  assign ack0      = capture_s && !sel_r;
  assign ack1      = capture_s &&  sel_r;
  assign sel       = sel_r;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign busy      = (state_r != IDLE);

endmodule

// File: tb/tb_mux2_arbiter.sv
// tb_mux2_arbiter: directed bench for mux2_arbiter. Expected output beats are
// queued before each burst is driven and popped by a monitor whenever the
// output stage hands a beat downstream.
module tb_mux2_arbiter;

  localparam int MAX_BURST   = 4;
  localparam int STALL_LIMIT = 16;

  logic       clk;
  logic       rst;
  logic       req0, last0, ack0;
  logic [7:0] data0;
  logic       req1, last1, ack1;
  logic [7:0] data1;
  logic       sel;
  logic [7:0] out_data;
  logic       out_valid, out_last, out_ready, busy;

  int         vectors     = 0;
  int         miscompares = 0;
  logic [8:0] sb[$];   // {last, data}

  mux2_arbiter #(.MAX_BURST(MAX_BURST), .STALL_LIMIT(STALL_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .data0(data0), .last0(last0), .ack0(ack0),
    .req1(req1), .data1(data1), .last1(last1), .ack1(ack1),
    .sel(sel), .out_data(out_data), .out_valid(out_valid),
    .out_last(out_last), .out_ready(out_ready), .busy(busy)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts, asserts, reports.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every accepted output beat must match the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      chk("sb_nonempty", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        logic [8:0] e;
        e = sb.pop_front();
        chk("out_data", out_data, e[7:0]);
        chk("out_last", out_last, e[8]);
      end
    end
  end

  // Drive n beats on one channel; waits counts cycles spent waiting for ack.
  task automatic send(input int ch, input int n, input logic [47:0] bytes,
                      input logic [5:0] lasts, output int waits);
    logic got;
    int   w;
    waits = 0;
    for (int i = 0; i < n; i++) begin
      if (ch == 0) begin
        req0 = 1'b1; data0 = bytes[8*i +: 8]; last0 = lasts[i];
      end else begin
        req1 = 1'b1; data1 = bytes[8*i +: 8]; last1 = lasts[i];
      end
      got = 1'b0;
      w   = 0;
      while (!got && w <= 200) begin
        @(negedge clk);
        if ((ch == 0) ? ack0 : ack1) begin
          got = 1'b1;
          chk($sformatf("sel_ch%0d", ch), sel, ch);
        end else begin
          w++;
        end
        @(posedge clk); #1;
      end
      chk("ack_timeout", got, 1);
      waits += w;
    end
    if (ch == 0) begin
      req0 = 1'b0; last0 = 1'b0;
    end else begin
      req1 = 1'b0; last1 = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Watchdog so a hung handshake still terminates the run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed sequence.
  initial begin
    int wa, wb;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = 8'h00; data1 = 8'h00;
    last0 = 1'b0; last1 = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset then idle.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_sel", sel, 0);
      chk("idle_out_valid", out_valid, 0);
      chk("idle_busy", busy, 0);
      chk("idle_ack0", ack0, 0);
      chk("idle_ack1", ack1, 0);
    end
    @(posedge clk); #1;

    // Contention: channel 0 first (prio=0), then channel 1.
    sb.push_back({1'b0, 8'hA0}); sb.push_back({1'b1, 8'hA1});
    sb.push_back({1'b0, 8'hB0}); sb.push_back({1'b1, 8'hB1});
    fork
      send(0, 2, 48'h0000_0000_A1A0, 6'b000010, wa);
      send(1, 2, 48'h0000_0000_B1B0, 6'b000010, wb);
    join
    idle(3);

    // Second simultaneous request: prio returned to 0.
    sb.push_back({1'b1, 8'hC0}); sb.push_back({1'b1, 8'hD0});
    fork
      send(0, 1, 48'h0000_0000_00C0, 6'b000001, wa);
      send(1, 1, 48'h0000_0000_00D0, 6'b000001, wb);
    join
    idle(3);

    // Single burst on channel 0: one arbitration cycle, then 3 acks back to back.
    sb.push_back({1'b0, 8'h11}); sb.push_back({1'b0, 8'h22}); sb.push_back({1'b1, 8'h33});
    send(0, 3, 48'h0000_0033_2211, 6'b000100, wa);
    chk("single_waits", wa, 1);
    idle(1);
    @(negedge clk);
    chk("single_busy_after", busy, 0);
    @(posedge clk); #1;
    idle(2);

    // Priority now 1: channel 1 wins the next simultaneous request.
    sb.push_back({1'b1, 8'hE1}); sb.push_back({1'b1, 8'hF0});
    fork
      send(0, 1, 48'h0000_0000_00F0, 6'b000001, wa);
      send(1, 1, 48'h0000_0000_00E1, 6'b000001, wb);
    join
    idle(3);

    // Backpressure: out_ready low for 3 cycles after the first capture.
    sb.push_back({1'b0, 8'h01}); sb.push_back({1'b1, 8'h02});
    req0 = 1'b1; data0 = 8'h01; last0 = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_ack_first", ack0, 1);
    @(posedge clk); #1;
    data0 = 8'h02; last0 = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold_data", out_data, 8'h01);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_ack_low", ack0, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_ack_resume", ack0, 1);
    @(posedge clk); #1;
    req0 = 1'b0; last0 = 1'b0;
    idle(3);

    // Forced cut after 4 beats, then re-grant for beats 5-6.
    sb.push_back({1'b0, 8'h61}); sb.push_back({1'b0, 8'h62});
    sb.push_back({1'b0, 8'h63}); sb.push_back({1'b1, 8'h64});
    sb.push_back({1'b0, 8'h65}); sb.push_back({1'b1, 8'h66});
    send(1, 6, 48'h6665_6463_6261, 6'b100000, wb);
    chk("cut_waits", wb, 2);
    idle(3);

    // Stall timeout: one non-last beat, then req0 dropped.
    sb.push_back({1'b0, 8'h77});
    send(0, 1, 48'h0000_0000_0077, 6'b000000, wa);
    for (int i = 0; i < STALL_LIMIT; i++) begin
      @(negedge clk);
      chk("stall_busy", busy, 1);
      chk("stall_no_last", out_last, 0);
    end
    @(negedge clk);
    chk("stall_released", busy, 0);
    chk("stall_no_last_end", out_last, 0);
    @(posedge clk); #1;
    idle(2);

    // Reset mid-burst with a beat pending in the output register.
    out_ready = 1'b0;
    req1 = 1'b1; data1 = 8'h5A; last1 = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_ack1", ack1, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_pending_valid", out_valid, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ack1_low", ack1, 0);
    chk("rst_sel", sel, 0);
    @(posedge clk); #1;
    rst = 1'b0; req1 = 1'b0; out_ready = 1'b1;
    idle(5);

    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
